// File: rtl/rr_arb_mux_4_1.sv
// rr_arb_mux_4_1: registered round-robin 4:1 arbiter-multiplexer.
// Picks one of four valid sources fairly and forwards its data. It also forwards
// a 2-bit index of the granted source for downstream muxes of the same width.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   per-source request
//   in_ready   per-source accept (one-hot or zero, combinational)
//   d0..d3     per-source data, WIDTH bits
//   out_valid  output register holds an item
//   out_ready  downstream accepts the item
//   out_data   registered data of the granted source
//   out_sel    registered index of the granted source
module rr_arb_mux_4_1 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    logic [1:0]       ptr;
    logic [1:0]       grant;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] grant_data;

    // The register can refill in the same cycle its current item drains.
    assign load = !out_valid || out_ready;
    assign any  = |in_valid;

    // Search from ptr upward with wrap. The first hit is the grant.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        grant = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Only the granted source's data is steered. Unknowns on the other
    // sources cannot reach the register.
    always_comb begin
        grant_data = '0;
        case (grant)
            2'd0:    grant_data = d0;
            2'd1:    grant_data = d1;
            2'd2:    grant_data = d2;
            default: grant_data = d3;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load && any) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant;
                ptr       <= grant + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
module tb_rr_arb_mux_4_1;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    int errors = 0;
    int checks = 0;
    int pushes = 0;
    int pops   = 0;
    logic [W+1:0] sb[$];

    rr_arb_mux_4_1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an item is consumed at the edge following a negedge that sees
    // out_valid && out_ready. It is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_item: got data=%h sel=%0d expected none", out_data, out_sel);
            end else begin
                logic [W+1:0] e;
                e = sb.pop_front();
                pops++;
                chk("out_data", 8'(out_data), 8'(e[W+1:2]));
                chk("out_sel",  8'(out_sel),  8'(e[1:0]));
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic [3:0] iv, input logic ordy, input logic [3:0] exp_rdy,
                        input bit push, input logic [W-1:0] ed, input logic [1:0] es,
                        input bit hold, input logic [W-1:0] hd, input logic [1:0] hs);
        in_valid  = iv;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", 8'(in_ready), 8'(exp_rdy));
        if (hold) begin
            chk("hold_valid", 8'(out_valid), 8'd1);
            chk("hold_data",  8'(out_data),  8'(hd));
            chk("hold_sel",   8'(out_sel),   8'(hs));
        end
        @(posedge clk);
        if (push) begin
            sb.push_back({ed, es});
            pushes++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  8'(in_ready),  8'h0);
        chk("rst_out_valid", 8'(out_valid), 8'h0);
        chk("rst_out_data",  8'(out_data),  8'h0);
        chk("rst_out_sel",   8'(out_sel),   8'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fair rotation: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            logic [1:0] s;
            logic [W-1:0] dv;
            s  = 2'(i);
            dv = 4'hA + 4'(s);
            step(4'hF, 1'b1, 4'b0001 << s, 1'b1, dv, s, 1'b0, '0, '0);
        end

        // Skip to 3, wrap to 0, then 1
        d3 = 4'h7; d0 = 4'h1; d1 = 4'h2;
        step(4'b1000, 1'b1, 4'b1000, 1'b1, 4'h7, 2'd3, 1'b0, '0, '0);
        step(4'b0011, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 1'b0, '0, '0);
        step(4'b0011, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1, 1'b0, '0, '0);

        // Backpressure: item 5 from source 2 held for 3 cycles
        d2 = 4'h5;
        step(4'b0100, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2, 1'b0, '0, '0);
        d3 = 4'h9;
        for (int i = 0; i < 3; i++)
            step(4'hF, 1'b0, 4'b0000, 1'b0, '0, '0, 1'b1, 4'h5, 2'd2);
        step(4'hF, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3, 1'b0, '0, '0);

        // Idle and X isolation
        d0 = 4'h3; d3 = 'x;
        step(4'b0001, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd0, 1'b0, '0, '0);
        step(4'b0000, 1'b1, 4'b0000, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("idle_out_valid", 8'(out_valid), 8'h0);
        d2 = 4'h6; d3 = 4'h8;
        step(4'b0100, 1'b1, 4'b0100, 1'b1, 4'h6, 2'd2, 1'b0, '0, '0);
        step(4'hF,    1'b1, 4'b1000, 1'b1, 4'h8, 2'd3, 1'b0, '0, '0);

        // Async reset mid-stall: the held item is discarded
        d1 = 4'h4;
        step(4'b0010, 1'b1, 4'b0010, 1'b0, '0, '0, 1'b0, '0, '0);
        step(4'b0000, 1'b0, 4'b0000, 1'b0, '0, '0, 1'b1, 4'h4, 2'd1);
        in_valid = 4'hF; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 8'(out_valid), 8'h0);
        chk("midrst_in_ready",  8'(in_ready),  8'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = 4'hE;
        step(4'hF, 1'b1, 4'b0001, 1'b1, 4'hE, 2'd0, 1'b0, '0, '0);
        step(4'h0, 1'b1, 4'b0000, 1'b0, '0, '0, 1'b0, '0, '0);
        step(4'h0, 1'b1, 4'b0000, 1'b0, '0, '0, 1'b0, '0, '0);

        chk("sb_empty", 8'(sb.size()), 8'd0);
        chk("pop_count", 8'(pops), 8'(pushes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
